// File: rtl/morse_pkg.sv
// Shared Morse symbol constants and encoder FSM states.
// Downstream lookup decodes morse_out with the same SYM_* values.
package morse_pkg;

  localparam int MORSE_W     = 10;
  localparam int MAX_SYMBOLS = 5;

  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_WAIT_WORD
  } state_t;

endpackage

// File: rtl/morse_key_encoder_debouncer.sv
// Two-flop synchronizer followed by a stable-count filter.
// The output follows the key only after DEBOUNCE_TICKS steady cycles.
module key_debouncer #(
  parameter int DEBOUNCE_TICKS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_key_db
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_key_db = r_db;

endmodule

// File: rtl/morse_key_encoder.sv
// Telegraph key front end: times presses and gaps on the debounced
// key and packs dots/dashes into a 10-bit symbol word with strobes.
module morse_key_encoder
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = 50000,
  parameter int DOT_MAX_TICKS    = 10000000,
  parameter int LETTER_GAP_TICKS = 15000000,
  parameter int WORD_GAP_TICKS   = 35000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_in,
  output logic [MORSE_W-1:0] morse_out,
  output logic               code_valid,
  output logic               overflow,
  output logic               busy
);

  localparam int PW = $clog2(DOT_MAX_TICKS + 1);
  localparam int GW = $clog2(WORD_GAP_TICKS + 1);
  localparam logic [PW-1:0] DOT_MAX = PW'(DOT_MAX_TICKS);
  localparam logic [GW-1:0] GAP_L   = GW'(LETTER_GAP_TICKS);
  localparam logic [GW-1:0] GAP_W   = GW'(WORD_GAP_TICKS);
  localparam logic [MORSE_W-1:0] EMPTY = {MAX_SYMBOLS{SYM_NONE}};

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_press, w_press_nxt;
  logic [GW-1:0]      r_gap, w_gap_nxt, w_gap_inc;
  logic [MORSE_W-1:0] r_buf, w_buf_nxt;
  logic [MORSE_W-1:0] r_out, w_out_nxt;
  logic [2:0]         r_n, w_n_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_cv, w_cv_nxt;
  logic               r_ov, w_ov_nxt;
  logic [1:0]         w_sym;
  logic               w_key_db;

  key_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .i_key   (key_in),
    .o_key_db(w_key_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_press_nxt = r_press;
    w_gap_nxt   = r_gap;
    w_buf_nxt   = r_buf;
    w_n_nxt     = r_n;
    w_ovf_nxt   = r_ovf;
    w_out_nxt   = r_out;
    w_cv_nxt    = 1'b0;
    w_ov_nxt    = 1'b0;
    w_gap_inc   = (r_gap == GAP_W) ? r_gap : r_gap + GW'(1);
    w_sym       = (r_press < DOT_MAX) ? SYM_DOT : SYM_DASH;
    unique case (r_state)
      ST_IDLE: begin
        w_buf_nxt = EMPTY;
        w_n_nxt   = '0;
        w_ovf_nxt = 1'b0;
        if (w_key_db) begin
          w_state_nxt = ST_PRESS;
          w_press_nxt = PW'(1);
        end
      end
      ST_PRESS: begin
        if (w_key_db) begin
          if (r_press != DOT_MAX) w_press_nxt = r_press + PW'(1);
        end else begin
          if (r_n < 3'(MAX_SYMBOLS)) begin
            w_buf_nxt = r_buf |
              ({w_sym, {(MORSE_W-2){1'b0}}} >> {r_n, 1'b0});
            w_n_nxt   = r_n + 3'd1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
          w_gap_nxt   = '0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        // Letter boundary beats a press starting on the same cycle.
        if (r_gap == GAP_L) begin
          if (r_ovf) begin
            w_ov_nxt  = 1'b1;
          end else begin
            w_out_nxt = r_buf;
            w_cv_nxt  = 1'b1;
          end
          w_buf_nxt   = EMPTY;
          w_n_nxt     = '0;
          w_ovf_nxt   = 1'b0;
          w_gap_nxt   = w_gap_inc;
          w_state_nxt = ST_WAIT_WORD;
        end else if (w_key_db) begin
          w_state_nxt = ST_PRESS;
          w_press_nxt = PW'(1);
        end else begin
          w_gap_nxt = w_gap_inc;
        end
      end
      ST_WAIT_WORD: begin
        if (w_key_db) begin
          w_state_nxt = ST_PRESS;
          w_press_nxt = PW'(1);
        end else if (r_gap == GAP_W) begin
          w_out_nxt   = '0;
          w_cv_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = w_gap_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_press <= '0;
      r_gap   <= '0;
      r_buf   <= '0;
      r_n     <= '0;
      r_ovf   <= 1'b0;
      r_out   <= '0;
      r_cv    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_press <= w_press_nxt;
      r_gap   <= w_gap_nxt;
      r_buf   <= w_buf_nxt;
      r_n     <= w_n_nxt;
      r_ovf   <= w_ovf_nxt;
      r_out   <= w_out_nxt;
      r_cv    <= w_cv_nxt;
      r_ov    <= w_ov_nxt;
    end
  end

  assign morse_out  = r_out;
  assign code_valid = r_cv;
  assign overflow   = r_ov;
  assign busy       = (r_state == ST_PRESS) || (r_state == ST_GAP);

endmodule

// File: tb/tb_morse_key_encoder.sv
// Directed and randomized key timing checked against a letter-level
// model of the Morse front end.
module tb_morse_key_encoder;

  localparam int DEB  = 4;
  localparam int DOTM = 20;
  localparam int LG   = 40;
  localparam int WG   = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [9:0] morse_out;
  logic       code_valid;
  logic       overflow;
  logic       busy;

  always #5 clk = ~clk;

  morse_key_encoder #(
    .DEBOUNCE_TICKS  (DEB),
    .DOT_MAX_TICKS   (DOTM),
    .LETTER_GAP_TICKS(LG),
    .WORD_GAP_TICKS  (WG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .morse_out (morse_out),
    .code_valid(code_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];
  logic [1:0]  m_syms[$];
  logic [9:0]  m_last = '0;

  int   n_both = 0;
  int   n_adj  = 0;
  logic prev_strobe = 1'b0;
  logic prev_busy   = 1'b0;
  logic sb_busy     = 1'b1;
  logic sb_prev     = 1'b0;

  always @(negedge clk) begin
    if (code_valid || overflow) begin
      got_q.push_back({overflow, morse_out});
      if (code_valid && overflow) n_both++;
      if (prev_strobe) n_adj++;
    end
    if (code_valid && morse_out != 10'd0) begin
      sb_busy = busy;
      sb_prev = prev_busy;
    end
    prev_strobe = code_valid || overflow;
    prev_busy   = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic m_press(input int len);
    m_syms.push_back(len >= DOTM ? 2'b11 : 2'b10);
  endtask

  // A letter ends on a released stretch longer than the letter gap,
  // a word on one longer than the word gap.
  task automatic m_gap(input int len);
    if (len > LG && m_syms.size() > 0) begin
      logic [9:0] v;
      v = '0;
      if (m_syms.size() > 5) begin
        exp_q.push_back({1'b1, m_last});
      end else begin
        for (int i = 0; i < m_syms.size(); i++)
          v[9-2*i -: 2] = m_syms[i];
        exp_q.push_back({1'b0, v});
        m_last = v;
      end
      m_syms.delete();
      if (len > WG) begin
        exp_q.push_back(11'd0);
        m_last = '0;
      end
    end
  endtask

  task automatic key(input int len);
    hold(1'b1, len);
    m_press(len);
  endtask

  task automatic gap(input int len);
    hold(1'b0, len);
    m_gap(len);
  endtask

  task automatic check_strobes(input string tag);
    int n;
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_strobe"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int ns;
    rst    = 1'b1;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_morse", morse_out, 0);
    chk("rst_cv", code_valid, 0);
    chk("rst_ov", overflow, 0);
    chk("rst_busy", busy, 0);

    key(10); gap(60);
    check_strobes("E");
    chk("busy_before_strobe", sb_prev, 1);
    chk("busy_at_strobe", sb_busy, 0);

    key(10); gap(15); key(30); gap(60);
    check_strobes("A");
    key(19); gap(60);
    key(20); gap(60);
    check_strobes("bound");

    for (int i = 0; i < 5; i++) begin
      key(30);
      if (i < 4) gap(10);
    end
    gap(60);
    check_strobes("five_dash");
    for (int i = 0; i < 6; i++) begin
      key(10);
      if (i < 5) gap(10);
    end
    gap(60);
    check_strobes("six_dot");
    chk("ovf_hold", morse_out, 10'b11_11_11_11_11);
    key(30); gap(10); key(10); gap(60);
    check_strobes("after_ovf");

    key(10); gap(150);
    hold(1'b0, 500);
    check_strobes("word");

    hold(1'b1, 2); hold(1'b0, 20);
    hold(1'b1, 3); hold(1'b0, 20);
    chk("glitch_busy", busy, 0);
    check_strobes("glitch");
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
    hold(1'b1, 12); hold(1'b0, 1); hold(1'b1, 1);
    m_press(14);
    gap(150);
    check_strobes("bounce");

    key(10); gap(15); key(30); gap(60);
    check_strobes("pre_rst");
    key(10); gap(15); key(30); gap(15);
    hold(1'b1, 10);
    rst = 1'b1;
    #1;
    chk("midrst_morse", morse_out, 0);
    chk("midrst_cv", code_valid, 0);
    chk("midrst_ov", overflow, 0);
    chk("midrst_busy", busy, 0);
    m_syms.delete();
    m_last = '0;
    key_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 10);
    key(25); gap(150);
    check_strobes("rst_T");

    for (int l = 0; l < 8; l++) begin
      ns = $urandom_range(1, 6);
      for (int s = 0; s < ns; s++) begin
        if ($urandom_range(0, 1) == 1) key($urandom_range(25, 35));
        else key($urandom_range(5, 15));
        if (s < ns - 1) gap($urandom_range(5, 30));
        else if (l == 7 || $urandom_range(0, 2) == 0)
          gap($urandom_range(130, 180));
        else gap($urandom_range(55, 90));
      end
    end
    check_strobes("rand");

    chk("both_high", n_both, 0);
    chk("adjacent", n_adj, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_key_encoder.md
# morse_key_encoder

Front-end stage of the Morse decoder path. It samples a single asynchronous telegraph-key input, debounces it, and times each press and gap. It packs dots and dashes into the 10-bit symbol word consumed by the Morse-to-ASCII lookup stage, and pulses a strobe when a letter or word space is complete. Output encoding per 2-bit slot, MSB slot first: dot = 2'b10, dash = 2'b11, empty = 2'b00.

## Interface
Parameters:
- DEBOUNCE_TICKS, default 50000: cycles the synchronized key must hold a level before the debounced level changes.
- DOT_MAX_TICKS, default 10000000: press length, in cycles of debounced high, at or above which a press counts as a dash.
- LETTER_GAP_TICKS, default 15000000: released cycles that end a letter.
- WORD_GAP_TICKS, default 35000000: released cycles that end a word. Must be greater than LETTER_GAP_TICKS.

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: asynchronous, active-high reset.
- key_in, input, 1: raw key, asynchronous, high = pressed.
- morse_out, output, 10: packed symbol word; held stable between strobes.
- code_valid, output, 1: one-cycle strobe; morse_out is new this cycle.
- overflow, output, 1: one-cycle strobe; letter exceeded 5 symbols and was discarded.
- busy, output, 1: high while a letter is partially entered (states PRESS and GAP).

## Operation
- Input conditioning: key_in passes through a 2-FF synchronizer, then the debouncer, producing key_db.
- The FSM runs on key_db only. States: IDLE, PRESS, GAP, WAIT_WORD.
- IDLE: buffer empty, symbol count 0. On key_db rising, go to PRESS.
- PRESS: press counter increments while key_db is high, saturating at DOT_MAX_TICKS. On key_db falling:
  - symbol = dot if count < DOT_MAX_TICKS, else dash.
  - If symbol count < 5: write the symbol into slot [9-2*n -: 2] and increment n.
  - Else set an internal overflow flag.
  - Clear the gap counter and go to GAP.
- GAP: gap counter increments while key_db is low.
  - On key_db rising: go to PRESS and clear the press counter.
  - On count == LETTER_GAP_TICKS:
    - No overflow flag: load morse_out with the buffer and pulse code_valid.
    - Overflow flag set: pulse overflow only; morse_out unchanged.
    - In both cases: clear the buffer, n and the flag, then go to WAIT_WORD. The gap counter keeps counting.
- WAIT_WORD:
  - On key_db rising: go to PRESS (new letter, same word).
  - On gap count == WORD_GAP_TICKS: load morse_out = 10'b0 (space), pulse code_valid, go to IDLE.
- Continued idling in IDLE emits nothing; exactly one space per word gap.
- The gap counter is sized $clog2(WORD_GAP_TICKS+1) and saturates; it never wraps.
- An overflowed letter followed by a word gap still emits the space.

## Timing
- Reset values: morse_out = 10'b0, code_valid = 0, overflow = 0, busy = 0. FSM in IDLE; counters, buffer and synchronizer cleared.
- Reset mid-letter discards the partial buffer; no strobe is issued.
- key_db latency from key_in: 2 synchronizer cycles plus DEBOUNCE_TICKS cycles. Pulses shorter than DEBOUNCE_TICKS never reach the FSM.
- Press boundary: exactly DOT_MAX_TICKS high cycles is a dash; DOT_MAX_TICKS-1 is a dot.
- Strobe timing:
  - code_valid or overflow is registered and asserts on the cycle after the gap counter reaches LETTER_GAP_TICKS (or WORD_GAP_TICKS).
  - Width is exactly 1 cycle.
  - code_valid and overflow are never high together.
- A press that begins on the same cycle the letter threshold is reached: the strobe wins for that cycle; the press counter starts on the next cycle, so the letter boundary takes precedence.
- There is no backpressure. The downstream stage is combinational and samples morse_out on code_valid.

## Structure
- Shared package morse_pkg holds:
  - SYM_DOT = 2'b10, SYM_DASH = 2'b11, SYM_NONE = 2'b00.
  - MORSE_W = 10, MAX_SYMBOLS = 5.
  - The FSM state enum.
- Downstream decoding uses the same symbol constants.
- One sub-module: key_debouncer, containing the synchronizer and the stable-count filter, parameterized by DEBOUNCE_TICKS.
- The FSM, counters and pack buffer live in the top module.

## Test plan
Parameters for all scenarios: DEBOUNCE=4, DOT_MAX=20, LETTER_GAP=40, WORD_GAP=100.
- Single letter: press 10 cycles, release 60 cycles -> one code_valid pulse with morse_out = 10'b10_00_00_00_00 ("E"); busy falls with the strobe.
- Mixed symbols: press 10, gap 15, press 30, release -> morse_out = 10'b10_11_00_00_00 ("A"). Check press boundaries 19 (dot) and 20 (dash).
- Five dashes then a gap -> 10'b11_11_11_11_11. Six dots -> overflow pulse, no code_valid, morse_out keeps its prior value, the next letter decodes cleanly.
- Word gap: letter "E", then release for 150 cycles -> code_valid at the letter gap, then code_valid with morse_out = 10'b0 at the word gap, and no further strobes over the next 500 cycles.
- Glitch rejection: 2-cycle and 3-cycle key_in pulses and bounce trains on a press edge -> exactly one symbol recorded per real press.
- Reset asserted mid-PRESS after two symbols -> all outputs 0 immediately. After release, a fresh "T" (press 25) yields 10'b11_00_00_00_00.
